// File: rtl/menu_bar_graph_if.sv
// rtl/menu_bar_graph_if.sv - pixel, navigation and selection bundle for menu_bar_graph
interface menu_bar_graph_if #(
    parameter int IDX_W = 3
);
    logic             refr_tick;
    logic [9:0]       pix_x;
    logic [9:0]       pix_y;
    logic             nav_next;
    logic             nav_prev;
    logic             confirm;
    logic             graph_on;
    logic [2:0]       graph_rgb;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;

    modport master (
        output refr_tick, pix_x, pix_y, nav_next, nav_prev, confirm,
        input  graph_on, graph_rgb, sel_valid, sel_idx
    );

    modport slave (
        input  refr_tick, pix_x, pix_y, nav_next, nav_prev, confirm,
        output graph_on, graph_rgb, sel_valid, sel_idx
    );
endinterface

// File: rtl/menu_bar_graph.sv
// rtl/menu_bar_graph.sv - menu bar renderer with cursor, confirm flash and optional blink (MENU_BLINK_EN)
module menu_bar_graph #(
    parameter int N_ITEMS      = 6,
    parameter int ITEM_W       = 80,
    parameter int ITEM_GAP     = 10,
    parameter int MARGIN       = 10,
    parameter int BAR_H        = 80,
    parameter int FLASH_FRAMES = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              reset,
    menu_bar_graph_if.slave   bus
);
    localparam int IDX_W = ($clog2(N_ITEMS) > 1) ? $clog2(N_ITEMS) : 1;
    localparam int PITCH = ITEM_W + ITEM_GAP;
    localparam int FC_W  = $clog2(FLASH_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ITEMS - 1);

    // Reject item counts or geometries that cannot fit the 640-pixel bar.
    if (N_ITEMS < 2 || N_ITEMS > 16) begin : g_bad_items
        $error("menu_bar_graph: N_ITEMS must be in 2..16");
    end
    if (MARGIN + N_ITEMS * PITCH - ITEM_GAP > 640) begin : g_bad_geom
        $error("menu_bar_graph: item row wider than the 640-pixel bar");
    end

    logic [IDX_W-1:0] cursor;
    logic [IDX_W-1:0] cursor_nxt;
    logic [IDX_W-1:0] disp_cursor;
    logic [IDX_W-1:0] flash_idx;
    logic [FC_W-1:0]  flash_cnt;
    logic             confirm_ok;
    logic             blink_vis;

    logic [10:0]      x11;
    logic [10:0]      y11;
    logic             in_bar;
    logic             in_row;
    logic             item_hit;
    logic [IDX_W-1:0] item_idx;
    logic [2:0]       rgb_nxt;

    // Cursor after this cycle's navigation; opposing pulses cancel.
    always_comb begin
        cursor_nxt = cursor;
        if (bus.nav_next && !bus.nav_prev) begin
            cursor_nxt = (cursor == LAST) ? '0 : cursor + 1'b1;
        end else if (bus.nav_prev && !bus.nav_next) begin
            cursor_nxt = (cursor == '0) ? LAST : cursor - 1'b1;
        end
    end

    assign confirm_ok = bus.confirm && (flash_cnt == '0);

    // Cursor, frame-latched display cursor, confirm flash and selection report.
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor        <= '0;
            disp_cursor   <= '0;
            flash_idx     <= '0;
            flash_cnt     <= '0;
            bus.sel_valid <= 1'b0;
            bus.sel_idx   <= '0;
        end else begin
            cursor        <= cursor_nxt;
            bus.sel_valid <= confirm_ok;
            if (bus.refr_tick) begin
                disp_cursor <= cursor;
            end
            if (confirm_ok) begin
                bus.sel_idx <= cursor_nxt;
                flash_idx   <= cursor_nxt;
                flash_cnt   <= FC_W'(FLASH_FRAMES);
            end else if (bus.refr_tick && flash_cnt != '0) begin
                flash_cnt <= flash_cnt - 1'b1;
            end
        end
    end

`ifdef MENU_BLINK_EN
    localparam int BC_W = $clog2(BLINK_FRAMES + 1);
    logic [BC_W-1:0] blink_cnt;

    // Frame-based blink; any user activity restarts it in the visible phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (bus.nav_next || bus.nav_prev || bus.confirm) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (bus.refr_tick) begin
            if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign blink_vis = 1'b1;
`endif

    assign x11    = {1'b0, bus.pix_x};
    assign y11    = {1'b0, bus.pix_y};
    assign in_bar = (x11 < 11'd640) && (y11 < 11'(BAR_H));
    assign in_row = (y11 >= 11'(MARGIN)) && (y11 < 11'(BAR_H - MARGIN));

    // Locate which item box, if any, spans the current column.
    always_comb begin
        item_hit = 1'b0;
        item_idx = '0;
        for (int k = 0; k < N_ITEMS; k++) begin
            if (x11 >= 11'(MARGIN + k * PITCH) && x11 < 11'(MARGIN + k * PITCH + ITEM_W)) begin
                item_hit = 1'b1;
                item_idx = IDX_W'(k);
            end
        end
    end

    // Colour priority: flash, highlighted cursor, plain box, bar background.
    always_comb begin
        rgb_nxt = 3'b000;
        if (in_bar) begin
            if (in_row && item_hit) begin
                if (flash_cnt != '0 && item_idx == flash_idx) begin
                    rgb_nxt = 3'b011;
                end else if (item_idx == disp_cursor && blink_vis) begin
                    rgb_nxt = 3'b110;
                end else begin
                    rgb_nxt = 3'b101;
                end
            end else begin
                rgb_nxt = 3'b111;
            end
        end
    end

    // Register the pixel stream for a fixed one-cycle latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.graph_on  <= 1'b0;
            bus.graph_rgb <= 3'b000;
        end else begin
            bus.graph_on  <= in_bar;
            bus.graph_rgb <= rgb_nxt;
        end
    end
endmodule

// File: tb/tb_menu_bar_graph.sv
// tb/tb_menu_bar_graph.sv - scoreboard bench for menu_bar_graph against a frame-level model
module tb_menu_bar_graph;
    localparam int N_ITEMS  = 6;
    localparam int ITEM_W   = 80;
    localparam int ITEM_GAP = 10;
    localparam int MARGIN   = 10;
    localparam int BAR_H    = 80;
    localparam int FLASH    = 8;
`ifdef MENU_BLINK_EN
    localparam int BLINK    = 2;
`else
    localparam int BLINK    = 30;
`endif

    typedef struct {
        logic       on;
        logic [2:0] rgb;
        logic       sv;
        logic [2:0] si;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    menu_bar_graph_if #(.IDX_W(3)) mif ();

    menu_bar_graph #(
        .N_ITEMS(N_ITEMS), .ITEM_W(ITEM_W), .ITEM_GAP(ITEM_GAP), .MARGIN(MARGIN),
        .BAR_H(BAR_H), .FLASH_FRAMES(FLASH), .BLINK_FRAMES(BLINK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(mif.slave)
    );

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int sel_seen = 0;
    int sel_exp  = 0;

    // Reference model state
    int m_cur, m_disp, m_fcnt, m_fidx, m_sel, m_bcnt;
    bit m_vis;

    int xs [21] = '{0, 9, 10, 89, 90, 99, 100, 179, 180, 459, 460, 539, 540,
                    549, 550, 629, 630, 639, 640, 700, 1023};
    int ys [8]  = '{0, 9, 10, 69, 70, 79, 80, 100};

    function automatic int ref_rgb(int x, int y);
        int k, off;
        if (!(x < 640 && y < BAR_H)) return 0;
        if (y >= MARGIN && y < BAR_H - MARGIN && x >= MARGIN) begin
            k   = (x - MARGIN) / (ITEM_W + ITEM_GAP);
            off = (x - MARGIN) % (ITEM_W + ITEM_GAP);
            if (k < N_ITEMS && off < ITEM_W) begin
                if (m_fcnt != 0 && k == m_fidx) return 3;
                if (k == m_disp && m_vis) return 6;
                return 5;
            end
        end
        return 7;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_disp = 0; m_fcnt = 0; m_fidx = 0; m_sel = 0; m_bcnt = 0; m_vis = 1;
    endtask

    task automatic step(input bit nn, input bit np, input bit cf, input bit rt,
                        input bit rs, input int x, input int y);
        exp_t e;
        int old;
        @(posedge clk);
        #1;
        reset         = rs;
        mif.nav_next  = nn;
        mif.nav_prev  = np;
        mif.confirm   = cf;
        mif.refr_tick = rt;
        mif.pix_x     = 10'(x);
        mif.pix_y     = 10'(y);
        if (rs) begin
            e.on = 0; e.rgb = 0; e.sv = 0; e.si = 0;
            model_reset();
        end else begin
            e.on  = (x < 640 && y < BAR_H);
            e.rgb = 3'(ref_rgb(x, y));
            e.sv  = cf && (m_fcnt == 0);
            old = m_cur;
            if (nn && !np) m_cur = (m_cur + 1) % N_ITEMS;
            else if (np && !nn) m_cur = (m_cur + N_ITEMS - 1) % N_ITEMS;
            if (rt) m_disp = old;
            if (cf && m_fcnt == 0) begin
                m_fcnt = FLASH; m_fidx = m_cur; m_sel = m_cur;
                sel_exp++;
            end else if (rt && m_fcnt > 0) begin
                m_fcnt--;
            end
`ifdef MENU_BLINK_EN
            if (nn || np || cf) begin
                m_vis = 1; m_bcnt = 0;
            end else if (rt) begin
                m_bcnt++;
                if (m_bcnt == BLINK) begin
                    m_bcnt = 0; m_vis = !m_vis;
                end
            end
`endif
            e.si = 3'(m_sel);
        end
        q.push_back(e);
    endtask

    task automatic pix_rand();
        step(0, 0, 0, 0, 0, $urandom_range(0, 700), $urandom_range(0, 100));
    endtask

    task automatic tick();
        step(0, 0, 0, 1, 0, $urandom_range(0, 700), $urandom_range(0, 100));
    endtask

    task automatic scan_points();
        foreach (ys[j]) foreach (xs[i]) step(0, 0, 0, 0, 0, xs[i], ys[j]);
    endtask

    // Monitor: each cycle, compare DUT outputs to the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                #2;
                n_checks++;
                if (mif.graph_on !== e.on || mif.graph_rgb !== e.rgb) begin
                    n_fail++;
                    $display("FAIL pixel t=%0t: got on=%b rgb=%b, want on=%b rgb=%b",
                             $time, mif.graph_on, mif.graph_rgb, e.on, e.rgb);
                end
                n_checks++;
                if (mif.sel_valid !== e.sv || mif.sel_idx !== e.si) begin
                    n_fail++;
                    $display("FAIL select t=%0t: got valid=%b idx=%0d, want valid=%b idx=%0d",
                             $time, mif.sel_valid, mif.sel_idx, e.sv, e.si);
                end
                if (mif.sel_valid === 1'b1) sel_seen++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d entries pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        mif.nav_next = 0; mif.nav_prev = 0; mif.confirm = 0; mif.refr_tick = 0;
        mif.pix_x = 0; mif.pix_y = 0;
        model_reset();

        // Reset state and first frame drawing
        repeat (3) step(0, 0, 0, 0, 1, $urandom_range(0, 700), $urandom_range(0, 100));
        scan_points();

        // nav_prev: unchanged until the frame tick, then item 5
        step(0, 1, 0, 0, 0, 20, 40);
        repeat (10) pix_rand();
        scan_points();
        tick();
        scan_points();

        // From reset: seven nexts land on item 1, confirm flashes it for 8 frames
        step(0, 0, 0, 0, 1, 0, 0);
        repeat (7) step(1, 0, 0, 0, 0, $urandom_range(0, 700), 40);
        step(0, 0, 1, 0, 0, 100, 40);
        for (int f = 0; f < 10; f++) begin
            step(0, 0, 0, 0, 0, 100, 40);
            step(0, 0, 0, 0, 0, 189, 40);
            step(0, 0, 0, 0, 0, 190, 40);
            step(0, 0, 0, 0, 0, 15, 40);
            if (f == 3) step(0, 0, 1, 0, 0, 100, 40);
            if (f == 5) step(1, 1, 0, 0, 0, 100, 40);
            repeat (4) pix_rand();
            tick();
        end

        // Reset in the middle of a flash
        step(0, 0, 1, 0, 0, 100, 40);
        repeat (4) tick();
        step(0, 0, 0, 0, 0, 100, 40);
        step(0, 0, 0, 0, 1, 100, 40);
        step(0, 0, 0, 0, 0, 100, 40);
        tick();
        step(0, 0, 0, 0, 0, 100, 40);
        step(0, 0, 0, 0, 0, 20, 40);

        // Blink observation over several idle frames
        for (int f = 0; f < 8; f++) begin
            step(0, 0, 0, 0, 0, 20, 40);
            step(0, 0, 0, 0, 0, 110, 40);
            if (f == 5) step(1, 0, 0, 0, 0, 300, 5);
            tick();
        end

        // Randomised frames
        for (int f = 0; f < 60; f++) begin
            for (int c = 0; c < 50; c++) begin
                step(($urandom % 12) == 0, ($urandom % 12) == 0, ($urandom % 20) == 0, 0,
                     ($urandom % 1500) == 0, $urandom_range(0, 700), $urandom_range(0, 100));
            end
            tick();
        end

        step(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #5;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        n_checks++;
        if (sel_seen != sel_exp) begin
            n_fail++;
            $display("FAIL sel_count: got %0d sel_valid pulses, want %0d", sel_seen, sel_exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/menu_bar_graph.md
# menu_bar_graph

Parametrised top-menu graphics generator for the text editor's VGA path. Draws a horizontal menu bar of `N_ITEMS` equally sized item boxes and highlights a cursor item that the block owns and moves itself from next/prev navigation pulses. It also flags item confirmation with a one-frame-accurate flash. It sits beside the text and cursor generators and feeds the RGB priority mux with a registered pixel stream.

## Interface
- `N_ITEMS`, 6, number of menu items (2..16)
- `ITEM_W`, 80, item box width in pixels
- `ITEM_GAP`, 10, horizontal gap between boxes
- `MARGIN`, 10, left and top/bottom inset of boxes inside the bar
- `BAR_H`, 80, bar height in lines; bar spans x 0..639, y 0..BAR_H-1
- `FLASH_FRAMES`, 8, frames a confirmed item shows the flash colour
- `BLINK_FRAMES`, 30, half-period of cursor blink in frames
- `clk` in 1 pixel clock
- `reset` in 1 synchronous, active-high
- `refr_tick` in 1 one-cycle pulse at start of vertical blank
- `pix_x`, `pix_y` in 10 current pixel coordinates
- `nav_next`, `nav_prev` in 1 one-cycle navigation pulses
- `confirm` in 1 one-cycle selection pulse
- `graph_on` out 1 pixel lies inside the bar
- `graph_rgb` out 3 pixel colour
- `sel_valid` out 1 one-cycle pulse: item confirmed
- `sel_idx` out IDX_W confirmed item index; IDX_W = max(1, clog2(N_ITEMS))

## Operation
- `cursor` register, 0..N_ITEMS-1:
  - `nav_next` increments it, wrapping N_ITEMS-1 -> 0.
  - `nav_prev` decrements it, wrapping 0 -> N_ITEMS-1.
  - Both asserted in the same cycle: no change.
- `disp_cursor` copies `cursor` only on `refr_tick`. Drawing always uses `disp_cursor`, so there is no mid-frame tearing.
- `confirm` (ignored while a flash is running):
  - Next cycle: `sel_valid` = 1, `sel_idx` = current `cursor`.
  - `flash_idx` is loaded with `cursor`.
  - `flash_cnt` is loaded with FLASH_FRAMES.
- `flash_cnt` decrements on each `refr_tick` and saturates at 0.
- `confirm` and `nav_*` in the same cycle: navigation is applied first, then the confirm captures the updated `cursor`.
- Item k occupies x in [MARGIN + k·(ITEM_W+ITEM_GAP), that + ITEM_W) and y in [MARGIN, BAR_H−MARGIN). All ranges are half-open.
- Colour priority, highest first:
  - `3'b011` for item `flash_idx` while `flash_cnt`≠0.
  - `3'b110` for item `disp_cursor` while the blink phase is visible.
  - `3'b101` for any other item box.
  - `3'b111` for the bar background.
  - `3'b000` with `graph_on` = 0 outside the bar.
- Geometry compares use 11-bit unsigned arithmetic, so no overflow is possible at x = 639.
- Elaboration requires MARGIN + N_ITEMS·(ITEM_W+ITEM_GAP) − ITEM_GAP ≤ 640.

## Timing
- Pixel path has a fixed 1-cycle latency. `graph_on`/`graph_rgb` at cycle t+1 reflect `pix_x`/`pix_y` at t.
- Navigation becomes visible at the first `refr_tick` after the pulse. It is displayed from the next frame onward.
- `sel_valid` is exactly 1 cycle wide, 1 cycle after `confirm`. `sel_idx` holds its value until the next confirm.
- Reset values:
  - `cursor`, `disp_cursor`, `flash_cnt`, blink counter = 0.
  - Blink phase = visible.
  - `graph_on`, `graph_rgb`, `sel_valid`, `sel_idx` = 0.
- Reset mid-frame or mid-flash aborts the flash and outputs black from the next cycle.

## Configuration
- `MENU_BLINK_EN` defined:
  - A frame counter increments on `refr_tick`.
  - Every BLINK_FRAMES ticks the counter clears and the blink phase toggles.
  - Navigation or confirm forces the phase visible and clears the counter.
- Undefined: the counter is not built and the cursor highlight is always visible.

## Test plan
- Reset, then scan a full frame -> cursor item 0 box at x 10..89, y 10..69 is `3'b110`; other boxes `3'b101`; bar background `3'b111`; (0,100) is black with `graph_on` = 0; every output is one cycle late.
- `nav_prev` from reset, then one `refr_tick` -> item 5 (x 460..539) highlighted; item 0 shows `3'b101`; mid-frame pixels before the tick still show item 0.
- 7 × `nav_next`, then `confirm` -> `sel_valid` single pulse, `sel_idx` = 1; item 1 shows `3'b011` for exactly 8 frames, then `3'b110`.
- `nav_next` and `nav_prev` in the same cycle -> cursor unchanged. A `confirm` during an active flash -> no `sel_valid`.
- Reset asserted with `flash_cnt` = 4 -> next cycle all outputs 0; flash gone in the next frame.
- `MENU_BLINK_EN` defined, BLINK_FRAMES = 2 -> highlight visible for 2 frames and hidden for 2 (hidden box shows `3'b101`). `nav_next` while hidden -> visible at the next frame.
